// File: rtl/sqr_pkg.sv
// Shared definitions for the square accumulator: FSM state encoding,
// default operand width and odd-number sequence constants.
package sqr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   localparam int unsigned ROOT_W_DEF = 8;
   localparam int unsigned ODD_INIT   = 1;
   localparam int unsigned ODD_STEP   = 2;

endpackage

// File: rtl/square_dp.sv
// Datapath for the square accumulator: running sum of odd numbers,
// current odd term and remaining-term counter.
module square_dp
   import sqr_pkg::*;
#(
   parameter int unsigned ROOT_W = ROOT_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  step,
   input  logic [ROOT_W-1:0]     root,
   output logic                  cnt_is_one,
   output logic [2*ROOT_W-1:0]   sum
);

   localparam int unsigned SQ_W  = 2 * ROOT_W;
   localparam int unsigned ODD_W = ROOT_W + 1;

   logic [SQ_W-1:0]   acc;
   logic [ODD_W-1:0]  odd;
   logic [ROOT_W-1:0] cnt;

   // sum is the accumulator value after the current step; the FSM latches it
   // into square on the final step so no extra cycle is needed.
   assign sum        = acc + SQ_W'(odd);
   assign cnt_is_one = (cnt == ROOT_W'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         odd <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         odd <= ODD_W'(ODD_INIT);
         cnt <= root;
      end else if (step) begin
         acc <= sum;
         odd <= odd + ODD_W'(ODD_STEP);
         cnt <= cnt - ROOT_W'(1);
      end
   end

endmodule

// File: rtl/square_acc.sv
// Multiplier-free squarer: root*root computed as the sum of the first
// root odd numbers, one term per clock, with a one-cycle done pulse.
module square_acc
   import sqr_pkg::*;
#(
   parameter int unsigned ROOT_W = ROOT_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ROOT_W-1:0]     root,
   output logic                  busy,
   output logic                  done,
   output logic [2*ROOT_W-1:0]   square
);

   localparam int unsigned SQ_W = 2 * ROOT_W;

   state_t          state;
   state_t          state_nx;
   logic            load;
   logic            step;
   logic            sq_load;
   logic            sq_zero;
   logic            cnt_is_one;
   logic [SQ_W-1:0] sum;

   square_dp #(
      .ROOT_W (ROOT_W)
   ) u_dp (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .step       (step),
      .root       (root),
      .cnt_is_one (cnt_is_one),
      .sum        (sum)
   );

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      sq_load  = 1'b0;
      sq_zero  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               if (root == '0) begin
                  state_nx = DONE;
                  sq_load  = 1'b1;
                  sq_zero  = 1'b1;
               end else begin
                  state_nx = ITER;
               end
            end
         end
         ITER: begin
            step = 1'b1;
            if (cnt_is_one) begin
               state_nx = DONE;
               sq_load  = 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         done   <= 1'b0;
         square <= '0;
      end else begin
         state <= state_nx;
         done  <= (state_nx == DONE);
         if (sq_load) begin
            square <= sq_zero ? '0 : sum;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/square_acc.md
SQUARE_ACC -- requirements
Module: square_acc

Interface
REQ-001 Parameter ROOT_W, default 8, root operand width; SQ_W = 2*ROOT_W is derived, not overridable.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 root  input  ROOT_W  unsigned operand; captured on the accepted start edge.
REQ-006 busy  output  1  high in ITER and DONE.
REQ-007 done  output  1  one-cycle pulse; square valid from this cycle.
REQ-008 square  output  SQ_W  unsigned root*root; held until the next result loads.

Function
REQ-009 Square SHALL be computed as a sum of the first root odd numbers (1+3+5+...); no multiplier.
REQ-010 FSM states: IDLE, ITER, DONE.
REQ-011 IDLE, start=1: load cnt<=root, acc<=0, odd<=1; go to ITER if root!=0, else DONE.
REQ-012 IDLE, start=0: hold all registers.
REQ-013 ITER, each edge: acc<=acc+odd, odd<=odd+2, cnt<=cnt-1; go to DONE when cnt==1.
REQ-014 Entering DONE loads square<=final acc (acc+odd if coming from ITER, 0 if root=0).
REQ-015 DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
REQ-016 Latency: done high in the cycle following edge root+1, counting the start-sampling edge as edge 1 (root=0 -> 1 edge; root=255 -> 256 edges).
REQ-017 start in ITER or DONE SHALL be ignored; it is not queued.
REQ-018 start in DONE's following IDLE cycle is accepted normally (back-to-back throughput = root+2 cycles).
REQ-019 Widths: acc SQ_W bits, odd ROOT_W+1 bits, cnt ROOT_W bits.
REQ-020 No overflow: max result is 65025 for ROOT_W=8, and odd never exceeds 511.
REQ-021 square SHALL NOT change except on entry to DONE or on reset.
REQ-022 root changes after the start edge SHALL have no effect on the current computation.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, with busy=0, done=0, square=0, and acc, odd, cnt = 0, regardless of state.
REQ-024 Reset mid-ITER SHALL abort without a done pulse; first start after release is accepted normally.
REQ-025 Start asserted on the edge at which reset deasserts SHALL be sampled by that edge only if reset is already high at that edge (no special handling).

Structure
REQ-026 Shared package sqr_pkg: state enum (IDLE, ITER, DONE), ROOT_W default, ODD init constant 1, ODD step constant 2.
REQ-027 One sub-module, square_dp: acc/odd/cnt registers and adder, with load/step controls; FSM and square/done registers stay in square_acc.
REQ-028 square_dp SHALL expose cnt_is_one so the FSM takes no arithmetic decisions.

Verification
REQ-029 Drive root=12, start pulse -> done exactly 13 edges after start edge, square=144, busy high 13 cycles.
REQ-030 Drive root=0 -> done after 1 edge, square=0, no ITER cycle.
REQ-031 Drive root=255 -> square=65025 after 256 edges; then root=1 back-to-back in the cycle after done -> square=1.
REQ-032 Drive root=7, then start=1 and root=3 during ITER -> ignored, square=49, single done pulse.
REQ-033 Drive root=200, then reset low at ITER edge 50 -> all outputs 0 asynchronously, no done; then root=5 -> square=25.
REQ-034 Sweep all root 0..255 against a reference model -> every square=root*root and latency=root+1.
